// File: rtl/gray_pkg.sv
// Shared types for the gray-code stream checker and its decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic [1:0] {
        STEP_FIRST   = 2'b00,
        STEP_UP      = 2'b01,
        STEP_DOWN    = 2'b10,
        STEP_INVALID = 2'b11
    } step_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

endpackage

// File: rtl/gray_to_bin.sv
// Gray-to-binary decoder, inverse of the binary-to-gray converter.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of the gray bits at and above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_stream_checker.sv
// Decodes a gray stream, classifies each step (first/up/down/invalid), tracks faults.
// Latency: 1 cycle, result registered in a one-entry output stage.
// Backpressure: in_ready = !out_valid || out_ready; output holds while stalled.
module gray_stream_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic [1:0]       out_step,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
    logic [WIDTH-1:0] out_bin_q, out_bin_d;
    step_e            out_step_q, out_step_d;
    logic             out_valid_q, out_valid_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] dec_bin;
    step_e            step;
    logic             accept;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (in_gray),
        .bin  (dec_bin)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Classify the incoming word against the reference; clear discards the reference.
    always_comb begin
        step = STEP_INVALID;
        if (clear || state_q == ST_EMPTY) begin
            step = STEP_FIRST;
        end else if (dec_bin == prev_bin_q + ONE) begin
            step = STEP_UP;
        end else if (dec_bin == prev_bin_q - ONE) begin
            step = STEP_DOWN;
        end
    end

    // Tracking FSM: clear restarts, an accept alongside clear seeds a fresh reference.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = accept ? ST_TRACK : ST_EMPTY;
        end else if (accept) begin
            case (state_q)
                ST_EMPTY: state_d = ST_TRACK;
                ST_TRACK: state_d = (step == STEP_INVALID) ? ST_FAULT : ST_TRACK;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

    // Reference, output stage and saturating error counter; clear never drops a pending output.
    always_comb begin
        prev_bin_d  = prev_bin_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_step_d  = out_step_q;
        err_d       = err_q;
        if (accept) begin
            prev_bin_d  = dec_bin;
            out_valid_d = 1'b1;
            out_bin_d   = dec_bin;
            out_step_d  = step;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clear) begin
            err_d = '0;
        end else if (accept && step == STEP_INVALID && err_q != '1) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            prev_bin_q  <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_step_q  <= STEP_FIRST;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_bin_q  <= prev_bin_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_step_q  <= out_step_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_step  = out_step_q;
    assign fault     = (state_q == ST_FAULT);
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Self-checking bench for gray_stream_checker: directed literal cases plus random traffic
// checked every cycle against an integer-level model and an in-order scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_gray_stream_checker;

    localparam int W       = 4;
    localparam int EW      = 8;
    localparam int MASK    = (1 << W) - 1;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam int S_FIRST = 0;
    localparam int S_UP    = 1;
    localparam int S_DOWN  = 2;
    localparam int S_INV   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_gray = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_bin;
    logic [1:0]    out_step;
    logic          fault;
    logic [EW-1:0] err_count;

    int n_pass = 0;
    int n_total = 0;

    // Model state (integers, derived from the classification rules).
    bit m_has = 0;
    bit m_ov = 0;
    bit m_fault = 0;
    int m_prev = 0;
    int m_bin = 0;
    int m_step = 0;
    int m_err = 0;
    bit will_acc = 0;
    int sb_q[$];
    int cur;
    int r;

    gray_stream_checker #(.WIDTH(W), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_step  (out_step),
        .fault     (fault),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Decode by searching for the binary value whose gray encoding matches.
    function automatic int decode(input logic [W-1:0] g);
        for (int b = 0; b <= MASK; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Behavioural model, advanced on each rising edge from the applied inputs.
    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            int b;
            int st;
            int d;
            acc = in_valid && (!m_ov || out_ready);
            st = S_FIRST;
            if (acc) begin
                b = decode(in_gray);
                d = (b - m_prev) & MASK;
                if (clear || !m_has) st = S_FIRST;
                else if (d == 1)     st = S_UP;
                else if (d == MASK)  st = S_DOWN;
                else                 st = S_INV;
                m_bin = b; m_step = st; m_ov = 1; m_prev = b; m_has = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (clear) begin
                m_fault = 0; m_err = 0;
                if (!acc) m_has = 0;
            end else if (acc && st == S_INV) begin
                m_fault = 1;
                if (m_err < ERR_MAX) m_err++;
            end
        end
    end

    // Asynchronous reset discards everything, including words awaiting consumption.
    always @(negedge rst_n) begin
        m_has = 0; m_ov = 0; m_fault = 0; m_err = 0;
        m_prev = 0; m_bin = 0; m_step = 0;
        sb_q.delete();
    end

    // Per-cycle compare against the model, plus an in-order accept/consume scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", int'(in_ready), int'(!m_ov || out_ready));
            check("out_valid", int'(out_valid), int'(m_ov));
            check("fault", int'(fault), int'(m_fault));
            check("err_count", int'(err_count), m_err);
            if (m_ov) begin
                check("out_bin", int'(out_bin), m_bin);
                check("out_step", int'(out_step), m_step);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_pop_on_empty", sb_q.size(), 1);
                else check("sb_bin", int'(out_bin), sb_q.pop_front());
            end
            will_acc = in_valid && in_ready;
            if (will_acc) sb_q.push_back(decode(in_gray));
        end else begin
            will_acc = 0;
        end
    end

    task automatic send(input logic [W-1:0] g, input int eb, input int es, input int ef, input int ee);
        @(posedge clk); #1;
        in_valid = 1'b1; in_gray = g; out_ready = 1'b1;
        @(negedge clk);
        check("send_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lit_valid", int'(out_valid), 1);
        check("lit_bin", int'(out_bin), eb);
        check("lit_step", int'(out_step), es);
        check("lit_fault", int'(fault), ef);
        check("lit_err", int'(err_count), ee);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_bin", int'(out_bin), 0);
        check("rst_out_step", int'(out_step), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_err", int'(err_count), 0);

        // Simple count-up run.
        send(4'b0000, 0, S_FIRST, 0, 0);
        send(4'b0001, 1, S_UP, 0, 0);
        send(4'b0011, 2, S_UP, 0, 0);

        // Wrap in both directions.
        do_clear();
        send(4'b1000, 15, S_FIRST, 0, 0);
        send(4'b0000, 0, S_UP, 0, 0);
        send(4'b1000, 15, S_DOWN, 0, 0);

        // Invalid jumps set the sticky fault; later valid steps still classify.
        do_clear();
        send(4'b0011, 2, S_FIRST, 0, 0);
        send(4'b1100, 8, S_INV, 1, 1);
        send(4'b1110, 11, S_INV, 1, 2);
        send(4'b1010, 12, S_UP, 1, 2);

        // Backpressure: one word accepted, then stall with output held.
        @(posedge clk); #1;
        in_valid = 1'b1; in_gray = 4'b1011; out_ready = 1'b0;
        @(posedge clk); #1;
        in_gray = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_bin_hold", int'(out_bin), 13);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_bin", int'(out_bin), 14);
        check("bp_next_step", int'(out_step), S_UP);

        // Random traffic: mostly +/-1 steps, some repeats and jumps, random stalls and clears.
        cur = 14;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (will_acc || !in_valid) begin
                r = $urandom_range(0, 7);
                if (r < 4)       cur = (cur + 1) & MASK;
                else if (r < 6)  cur = (cur - 1) & MASK;
                else if (r == 7) cur = $urandom_range(0, MASK);
                in_gray  = to_gray(cur);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        // Error counter saturation with a repeated word.
        do_clear();
        @(posedge clk); #1;
        in_valid = 1'b1; in_gray = 4'b0101; out_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("sat_err", int'(err_count), ERR_MAX);
        check("sat_fault", int'(fault), 1);

        // Clear together with an accept while faulted with three errors.
        do_clear();
        send(4'b0000, 0, S_FIRST, 0, 0);
        send(4'b0111, 5, S_INV, 1, 1);
        send(4'b1101, 9, S_INV, 1, 2);
        send(4'b0010, 3, S_INV, 1, 3);
        @(posedge clk); #1;
        clear = 1'b1; in_valid = 1'b1; in_gray = 4'b0100; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("clracc_bin", int'(out_bin), 7);
        check("clracc_step", int'(out_step), S_FIRST);
        check("clracc_fault", int'(fault), 0);
        check("clracc_err", int'(err_count), 0);
        // Clear alone leaves the pending output intact.
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_pend_valid", int'(out_valid), 1);
        check("clr_pend_bin", int'(out_bin), 7);
        check("clr_pend_step", int'(out_step), S_FIRST);
        send(4'b1100, 8, S_FIRST, 0, 0);
        send(4'b1111, 10, S_INV, 1, 1);

        // Asynchronous reset mid-stream with a pending output.
        @(posedge clk); #1;
        in_valid = 1'b1; in_gray = 4'b0110; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_bin", int'(out_bin), 0);
        check("arst_out_step", int'(out_step), 0);
        check("arst_fault", int'(fault), 0);
        check("arst_err", int'(err_count), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        send(4'b0011, 2, S_FIRST, 0, 0);
        send(4'b0010, 3, S_UP, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
